// File: rtl/inst_sram_pkg.sv
// Shared definitions for the instruction SRAM controller: FSM state encoding,
// pipeline depth limit and the parameter legality check used at elaboration.
package inst_sram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int LATENCY_MAX = 4;

  function automatic bit params_ok(input int addr_w, input int data_w,
                                   input int depth, input int latency);
    return (data_w >= 8) && (data_w % 8 == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (latency >= 1) && (latency <= LATENCY_MAX) &&
           (addr_w >= $clog2(data_w / 8) + $clog2(depth));
  endfunction

endpackage

// File: rtl/inst_sram_resp_pipe.sv
// Fixed-latency response pipeline: a valid bit shifts every cycle while the
// data/err payload only advances with it, so the output holds between responses.
module inst_sram_resp_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= in_data;
        err_q[0] <= in_err;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];

endmodule

// File: rtl/inst_sram_ctrl.sv
// Single-port SRAM controller with byte strobes, range checking, optional
// zero-fill after reset and a fixed request-to-response latency.
module inst_sram_ctrl
  import inst_sram_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4096,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy
);

  localparam int  NB        = DATA_W / 8;
  localparam int  OFF_W     = $clog2(NB);
  localparam int  IDX_W     = $clog2(DEPTH);
  localparam int  HI_W      = ADDR_W - OFF_W - IDX_W;
  localparam bit  PARAMS_OK = params_ok(ADDR_W, DATA_W, DEPTH, LATENCY);

  if (!PARAMS_OK) begin : g_bad_params
    $error("inst_sram_ctrl: illegal parameter combination");
  end

  sram_state_e      state_q;
  logic             run_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic [IDX_W-1:0] idx;
  logic             oor;
  logic             accept;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign idx = addr[OFF_W +: IDX_W];

  // Any address bit above the word index means the word lies past the array.
  if (HI_W > 0) begin : g_range
    assign oor = |addr[ADDR_W-1 -: HI_W];
  end else begin : g_no_range
    assign oor = 1'b0;
  end

  if (OFF_W > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^addr[OFF_W-1:0];
  end

  // run_q keeps addr_ok low through the first edge after release even when no clear runs.
  assign addr_ok = (state_q == ST_READY) && run_q;
  assign busy    = (state_q == ST_CLEAR);
  assign accept  = req && addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      run_q     <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (state_q == ST_CLEAR) begin
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_q   <= ST_READY;
          clr_cnt_q <= '0;
        end else begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: the array has no reset branch; it is zeroed by the CLEAR walk so it can map onto a real SRAM macro.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (accept && wr && !oor) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  inst_sram_resp_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (accept),
    .in_data   ((wr || oor) ? '0 : mem_q[idx]),
    .in_err    (oor),
    .out_valid (data_ok),
    .out_data  (rdata),
    .out_err   (err)
  );

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed bench for inst_sram_ctrl with DEPTH=16, LATENCY=3, zero-fill on reset.
module tb_inst_sram_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req;
  logic              wr;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t rq[$];

  inst_sram_ctrl #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .LATENCY        (LAT),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are sampled mid-cycle and tagged with the number of edges seen so far.
  always @(negedge clk) begin
    if (data_ok === 1'b1) rq.push_back('{cyc, rdata, err});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; acc is the edge count just after acceptance.
  task automatic drive(input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
    @(negedge clk);
    req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; wr = 1'b0; wstrb = '0; addr = '0; wdata = '0;
  endtask

  task automatic get_resp(input string tag, output resp_t r);
    int n = 0;
    while (rq.size() == 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      check({tag, " timeout"}, 64'(rq.size()), 64'd1);
      r = '{-1, '0, 1'b0};
    end else begin
      r = rq.pop_front();
    end
  endtask

  // Response for acceptance at edge count acc is visible once LAT-1 further edges have passed.
  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
    int acc;
    resp_t r;
    drive(1'b0, 4'h0, a, 32'h0, acc);
    idle();
    get_resp(tag, r);
    check({tag, " rdata"}, 64'(r.data), 64'(exp_d));
    check({tag, " err"}, 64'(r.err), 64'(exp_e));
    check({tag, " latency"}, 64'(r.cyc), 64'(acc + LAT - 1));
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_e);
    int acc;
    resp_t r;
    drive(1'b1, s, a, d, acc);
    idle();
    get_resp(tag, r);
    check({tag, " rdata"}, 64'(r.data), 64'h0);
    check({tag, " err"}, 64'(r.err), 64'(exp_e));
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " busy cycles"}, 64'(n), 64'd16);
    check({tag, " addr_ok"}, 64'(addr_ok), 64'd1);
  endtask

  initial begin
    int acc[4];
    resp_t r;
    logic [31:0] exp4 [4];

    resetn = 1'b0; req = 1'b0; wr = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst addr_ok", 64'(addr_ok), 64'd0);
    check("rst data_ok", 64'(data_ok), 64'd0);
    check("rst rdata", 64'(rdata), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst busy", 64'(busy), 64'd1);

    resetn = 1'b1;
    count_busy("clear1");
    do_read("rd zero w5", 32'h14, 32'h0, 1'b0);
    do_read("rd zero w15", 32'h3C, 32'h0, 1'b0);

    // Write immediately followed by a read of the same word.
    drive(1'b1, 4'hF, 32'h8, 32'hDEADBEEF, acc[0]);
    drive(1'b0, 4'h0, 32'h8, 32'h0, acc[1]);
    idle();
    get_resp("wr 0x8", r);
    check("wr 0x8 rdata", 64'(r.data), 64'h0);
    check("wr 0x8 latency", 64'(r.cyc), 64'(acc[0] + LAT - 1));
    get_resp("rd 0x8", r);
    check("rd 0x8 rdata", 64'(r.data), 64'hDEADBEEF);
    check("rd 0x8 latency", 64'(r.cyc), 64'(acc[1] + LAT - 1));
    @(negedge clk);
    check("hold data_ok", 64'(data_ok), 64'd0);
    check("hold rdata", 64'(rdata), 64'hDEADBEEF);

    do_write("wr full 0xC", 32'hC, 32'h11223344, 4'hF, 1'b0);
    do_write("wr strb5 0xC", 32'hC, 32'hAABBCCDD, 4'h5, 1'b0);
    do_read("rd merged 0xC", 32'hC, 32'h11BB33DD, 1'b0);

    do_write("wr strb0 0x8", 32'h8, 32'h12345678, 4'h0, 1'b0);
    do_read("rd offset 0x9", 32'h9, 32'hDEADBEEF, 1'b0);

    // Four back-to-back reads come back on consecutive cycles in order.
    do_write("wr 0x0", 32'h0, 32'hCAFE0001, 4'hF, 1'b0);
    exp4[0] = 32'hDEADBEEF; exp4[1] = 32'h11BB33DD; exp4[2] = 32'h0; exp4[3] = 32'hCAFE0001;
    drive(1'b0, 4'h0, 32'h8, 32'h0, acc[0]);
    drive(1'b0, 4'h0, 32'hC, 32'h0, acc[1]);
    drive(1'b0, 4'h0, 32'h14, 32'h0, acc[2]);
    drive(1'b0, 4'h0, 32'h0, 32'h0, acc[3]);
    idle();
    for (int i = 0; i < 4; i++) begin
      get_resp($sformatf("burst%0d", i), r);
      check($sformatf("burst%0d rdata", i), 64'(r.data), 64'(exp4[i]));
      check($sformatf("burst%0d cycle", i), 64'(r.cyc), 64'(acc[0] + LAT - 1 + i));
    end

    // Out-of-range accesses: error response, and no aliasing onto word 0.
    do_read("rd oor 0x40", 32'h40, 32'h0, 1'b1);
    @(negedge clk);
    check("hold err", 64'(err), 64'd1);
    do_write("wr oor 0x40", 32'h40, 32'hFFFFFFFF, 4'hF, 1'b1);
    do_read("rd after oor w0", 32'h0, 32'hCAFE0001, 1'b0);
    do_read("rd after oor w2", 32'h8, 32'hDEADBEEF, 1'b0);
    do_read("rd after oor w3", 32'hC, 32'h11BB33DD, 1'b0);
    check("queue empty pre-reset", 64'(rq.size()), 64'd0);

    // Reset with two reads in flight: nothing may come out, and the array is re-zeroed.
    drive(1'b0, 4'h0, 32'h0, 32'h0, acc[0]);
    drive(1'b0, 4'h0, 32'h8, 32'h0, acc[1]);
    resetn = 1'b0;
    req = 1'b0;
    #1;
    check("mid rst data_ok", 64'(data_ok), 64'd0);
    check("mid rst busy", 64'(busy), 64'd1);
    check("mid rst addr_ok", 64'(addr_ok), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    count_busy("clear2");
    repeat (6) @(posedge clk);
    check("no stale data_ok", 64'(rq.size()), 64'd0);
    do_read("rd cleared w0", 32'h0, 32'h0, 1'b0);
    do_read("rd cleared w2", 32'h8, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_sram_ctrl.md
INST_SRAM_CTRL -- requirements
Module: inst_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width, a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 4096, words stored, a power of 2.
REQ-004 SHALL have parameter LATENCY, default 1, request-to-response cycles, legal range 1..4.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the array after reset.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port req  in  1  request valid.
REQ-009 SHALL have port wr  in  1  1 = write, 0 = read.
REQ-010 SHALL have port wstrb  in  DATA_W/8  byte write enables.
REQ-011 SHALL have port addr  in  ADDR_W  byte address.
REQ-012 SHALL have port wdata  in  DATA_W  write data.
REQ-013 SHALL have port addr_ok  out  1  request accepted this cycle.
REQ-014 SHALL have port data_ok  out  1  response valid.
REQ-015 SHALL have port rdata  out  DATA_W  read data.
REQ-016 SHALL have port err  out  1  response is out-of-range, qualified by data_ok.
REQ-017 SHALL have port busy  out  1  array clear in progress.

Function
REQ-018 SHALL use a two-state FSM: CLEAR (busy=1, addr_ok=0) and READY (busy=0, addr_ok=1).
REQ-019 SHALL, in CLEAR, write zero to one word per cycle from index 0 to DEPTH-1, then enter READY on the edge after the write to DEPTH-1 (DEPTH cycles total).
REQ-020 SHALL, with CLEAR_ON_RESET=0, enter READY on the first edge after reset release and leave array contents undefined.
REQ-021 SHALL accept a request on a rising edge where req and addr_ok are both 1; req with addr_ok=0 is ignored with no side effects.
REQ-022 SHALL use word index addr[$clog2(DATA_W/8) +: $clog2(DEPTH)] and ignore the byte-offset bits.
REQ-023 SHALL treat addr >> $clog2(DATA_W/8) >= DEPTH as out of range: no write, response rdata=0, err=1.
REQ-024 SHALL, on an accepted in-range write, update only the bytes whose wstrb bit is 1, at the acceptance edge; wstrb=0 leaves the word unchanged.
REQ-025 SHALL return exactly one response per accepted request, exactly LATENCY cycles after acceptance, in order, at one per cycle with no bubbles.
REQ-026 SHALL drive rdata as the addressed word for reads and 0 for write responses.
REQ-027 SHALL make a read accepted on the edge after a write to the same word return the written data.
REQ-028 SHALL hold rdata and err at their last values while data_ok=0.
REQ-029 SHALL have no response backpressure; the requester always accepts data_ok.

Reset
REQ-030 SHALL, while resetn=0, force addr_ok=0, data_ok=0, rdata=0, err=0, busy=CLEAR_ON_RESET, FSM=CLEAR (or READY if CLEAR_ON_RESET=0), and clear counter=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all in-flight responses with no data_ok afterwards; the clear sequence restarts from index 0.

Structure
REQ-032 SHALL define the FSM state enum, LATENCY_MAX=4, and the parameter legality checks in shared package inst_sram_pkg.
REQ-033 SHALL place the LATENCY-deep valid/data/err shift pipeline in sub-module inst_sram_resp_pipe.

Verification
REQ-034 SHALL cover: DEPTH=16, CLEAR_ON_RESET=1, reset release -> busy=1 for exactly 16 cycles, then addr_ok=1; a read of any word returns 0.
REQ-035 SHALL cover: write addr=0x8, wdata=0xDEADBEEF, wstrb=0xF, then on the next edge a read of 0x8 -> data_ok after LATENCY cycles with rdata=0xDEADBEEF.
REQ-036 SHALL cover: write 0x11223344 at wstrb=0xF, then write 0xAABBCCDD at wstrb=0x5, then read -> 0x11BB33DD.
REQ-037 SHALL cover: LATENCY=3, reads on 4 consecutive edges -> 4 consecutive data_ok pulses starting 3 cycles after the first, in order.
REQ-038 SHALL cover: DEPTH=16, read addr=0x40 -> data_ok with err=1 and rdata=0; a write to 0x40 leaves all words unchanged.
REQ-039 SHALL cover: reset asserted with 2 reads in flight -> no data_ok during or after reset; the clear restarts from index 0.
